bullcow_match_scheduler: RTL

Match-level controller that sits between the board and the Bull/Cow game core. It debounces the raw Enter button and issues one-cycle enter pulses to the core. It runs a per-turn countdown during guess phases and records timeout strikes per player. It ends the match when a player reaches the win target or exhausts the strike limit.

---
 rtl/bullcow_match_scheduler.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bullcow_match_scheduler.sv
// Match-level scheduler for the Bull/Cow core: debounced enter pulses, per-turn
// countdown with timeout strikes, and match win/forfeit detection.
module bullcow_match_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int TURN_SECONDS    = 30,
  parameter int MAX_STRIKES     = 3,
  parameter int WIN_TARGET      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_enter,
  input  logic       match_restart,
  input  logic [2:0] game_state,
  input  logic [7:0] j1_points,
  input  logic [7:0] j2_points,
  output logic       game_enter,
  output logic       active_player,
  output logic [7:0] seconds_left,
  output logic       timeout_pulse,
  output logic [2:0] j1_strikes,
  output logic [2:0] j2_strikes,
  output logic       match_over,
  output logic       match_winner
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int TKW = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {SETUP, TURN, OVER} state_t;

  state_t           state;
  logic             sync1, sync2;
  logic             db_level, db_prev;
  logic [DBW-1:0]   db_cnt;
  logic [TKW-1:0]   tick;
  logic             turn_player;
  logic [7:0]       j1_base, j2_base;

  logic       in_guess, tick_wrap, turn_change, db_rise;
  logic       j1_win, j2_win, j1_out, j2_out, go_over, winner_next;
  logic [7:0] j1_delta, j2_delta;

  assign in_guess    = (game_state == 3'b010) || (game_state == 3'b011);
  assign tick_wrap   = (tick == TKW'(TICK_CYCLES - 1));
  assign turn_change = in_guess && (game_state[0] != turn_player);
  assign db_rise     = db_level && !db_prev;

  // Modulo-256 deltas so the counters may wrap without breaking the win check.
  assign j1_delta    = j1_points - j1_base;
  assign j2_delta    = j2_points - j2_base;
  assign j1_win      = (j1_delta >= 8'(WIN_TARGET));
  assign j2_win      = (j2_delta >= 8'(WIN_TARGET));
  assign j1_out      = (j1_strikes >= 3'(MAX_STRIKES));
  assign j2_out      = (j2_strikes >= 3'(MAX_STRIKES));
  assign go_over     = (state != OVER) && (j1_win || j2_win || j1_out || j2_out);
  // Points beat strikes; a strike forfeit hands the match to the opponent.
  assign winner_next = j1_win ? 1'b0 : (j2_win ? 1'b1 : j1_out);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_enter;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_level <= sync2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= SETUP;
      tick          <= '0;
      turn_player   <= 1'b0;
      j1_base       <= '0;
      j2_base       <= '0;
      game_enter    <= 1'b0;
      active_player <= 1'b0;
      seconds_left  <= '0;
      timeout_pulse <= 1'b0;
      j1_strikes    <= '0;
      j2_strikes    <= '0;
      match_over    <= 1'b0;
      match_winner  <= 1'b0;
    end else begin
      // NOTE: defaults ahead of the case make the pulse outputs single-cycle.
      timeout_pulse <= 1'b0;
      active_player <= game_state[0];
      game_enter    <= db_rise && (state != OVER) && !go_over;

      unique case (state)
        SETUP: begin
          if (go_over) begin
            state        <= OVER;
            match_over   <= 1'b1;
            match_winner <= winner_next;
          end else begin
            seconds_left <= 8'(TURN_SECONDS);
            tick         <= '0;
            if (in_guess) begin
              state       <= TURN;
              turn_player <= game_state[0];
            end
          end
        end

        TURN: begin
          if (go_over) begin
            state        <= OVER;
            match_over   <= 1'b1;
            match_winner <= winner_next;
          end else if (!in_guess) begin
            state        <= SETUP;
            seconds_left <= 8'(TURN_SECONDS);
            tick         <= '0;
          end else if (turn_change) begin
            // A turn change overrides any coincident tick wrap or timeout.
            turn_player  <= game_state[0];
            seconds_left <= 8'(TURN_SECONDS);
            tick         <= '0;
          end else if (tick_wrap) begin
            tick <= '0;
            if (seconds_left == 8'd1) begin
              timeout_pulse <= 1'b1;
              seconds_left  <= 8'(TURN_SECONDS);
              if (!turn_player) begin
                if (j1_strikes < 3'(MAX_STRIKES)) j1_strikes <= j1_strikes + 3'd1;
              end else begin
                if (j2_strikes < 3'(MAX_STRIKES)) j2_strikes <= j2_strikes + 3'd1;
              end
            end else begin
              seconds_left <= seconds_left - 8'd1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        OVER: begin
          if (match_restart) begin
            state      <= SETUP;
            match_over <= 1'b0;
            j1_strikes <= '0;
            j2_strikes <= '0;
            j1_base    <= j1_points;
            j2_base    <= j2_points;
          end
        end

        default: state <= SETUP;
      endcase
    end
  end

endmodule
